// File: rtl/pll_seq_pkg.sv
// Shared state encoding and widths for the PLL reset sequencer.
// Pure definitions: no latency, no flow control.
package pll_seq_pkg;

  localparam int LOST_CNT_W = 8;

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_ENABLE    = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  typedef enum logic [2:0] {
    ST_PLL_RST   = S_PLL_RST,
    ST_WAIT_LOCK = S_WAIT_LOCK,
    ST_STABLE    = S_STABLE,
    ST_ENABLE    = S_ENABLE,
    ST_RUN       = S_RUN
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
// Latency: input change visible on q after the second clock edge; no flow control.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL bring-up sequencer: pulses pll_reset, qualifies lock, staggers enclk, then releases sys_rst.
// All outputs registered; lock loss reacts 2 edges after pll_lock falls (synchroniser) + 1 edge.
// Optional PLL_SEQ_TIMEOUT_EN retries the PLL when lock is not reached within LOCK_TIMEOUT_CYCLES.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int NUM_CLK             = 3,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int ENCLK_GAP_CYCLES    = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  relock_req,
  output logic                  pll_reset,
  output logic [NUM_CLK-1:0]    pll_enclk,
  output logic                  sys_rst,
  output logic                  ready,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

  // One counter spans STABLE and ENABLE, measured from STABLE entry.
  localparam int SEQ_LAST = LOCK_STABLE_CYCLES + NUM_CLK * ENCLK_GAP_CYCLES;
  localparam int CNT_W    = $clog2(max_int(PLL_RST_CYCLES, SEQ_LAST)) + 1;

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        edge_num;
  logic                    pll_reset_q, pll_reset_d;
  logic [NUM_CLK-1:0]      enclk_q, enclk_d;
  logic                    sys_rst_q, sys_rst_d;
  logic                    ready_q, ready_d;
  logic [LOST_CNT_W-1:0]   lost_cnt_q, lost_cnt_d;
  logic                    reseq;
  logic                    count_loss;
  logic                    lock_s;

  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  localparam int unused_timeout_cycles = LOCK_TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pll_reset_d = pll_reset_q;
    enclk_d     = enclk_q;
    sys_rst_d   = sys_rst_q;
    ready_d     = ready_q;
    lost_cnt_d  = lost_cnt_q;
    edge_num    = cnt_q + CNT_W'(1);
    reseq       = 1'b0;
    count_loss  = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        if (edge_num == CNT_W'(PLL_RST_CYCLES)) begin
          state_d     = ST_WAIT_LOCK;
          pll_reset_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = edge_num;
        end
      end
      ST_WAIT_LOCK: begin
        if (relock_req) begin
          reseq = 1'b1;
        end else if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (relock_req) begin
          reseq = 1'b1;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = edge_num;
          if (edge_num == CNT_W'(LOCK_STABLE_CYCLES)) begin
            state_d    = ST_ENABLE;
            enclk_d[0] = 1'b1;
          end
        end
      end
      ST_ENABLE: begin
        if (relock_req || !lock_s) begin
          reseq      = 1'b1;
          count_loss = !lock_s;
        end else begin
          cnt_d = edge_num;
          for (int i = 1; i < NUM_CLK; i++) begin
            if (edge_num == CNT_W'(LOCK_STABLE_CYCLES + i * ENCLK_GAP_CYCLES)) begin
              enclk_d[i] = 1'b1;
            end
          end
          if (edge_num == CNT_W'(SEQ_LAST)) begin
            state_d   = ST_RUN;
            sys_rst_d = 1'b0;
            ready_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (relock_req || !lock_s) begin
          reseq      = 1'b1;
          count_loss = !lock_s;
        end
      end
      default: begin
        reseq = 1'b1;
      end
    endcase

`ifdef PLL_SEQ_TIMEOUT_EN
    // Dwell accumulates across WAIT_LOCK/STABLE bounces until the next PLL reset.
    to_cnt_d = to_cnt_q;
    if (state_q == ST_PLL_RST) begin
      to_cnt_d = '0;
    end else if (state_q == ST_WAIT_LOCK || state_q == ST_STABLE) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_d == TO_W'(LOCK_TIMEOUT_CYCLES)) begin
        reseq      = 1'b1;
        count_loss = 1'b1;
      end
    end
`endif

    if (reseq) begin
      state_d     = ST_PLL_RST;
      cnt_d       = '0;
      pll_reset_d = 1'b1;
      enclk_d     = '0;
      sys_rst_d   = 1'b1;
      ready_d     = 1'b0;
    end

    if (count_loss && (lost_cnt_q != {LOST_CNT_W{1'b1}})) begin
      lost_cnt_d = lost_cnt_q + LOST_CNT_W'(1);
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      enclk_q     <= '0;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      enclk_q     <= enclk_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign pll_enclk     = enclk_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: edge-accurate expectations computed from the sequencing rules.
// The timeout scenario follows PLL_SEQ_TIMEOUT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_pll_reset_seq;

  localparam int NC  = 3;
  localparam int PR  = 4;
  localparam int LS  = 8;
  localparam int GAP = 2;
  localparam int TO  = 32;

  logic          clkin = 1'b0;
  logic          reset;
  logic          pll_lock;
  logic          relock_req;
  logic          pll_reset;
  logic [NC-1:0] pll_enclk;
  logic          sys_rst;
  logic          ready;
  logic [7:0]    lock_lost_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rel_cyc = 0;

  pll_reset_seq #(
    .NUM_CLK             (NC),
    .PLL_RST_CYCLES      (PR),
    .LOCK_STABLE_CYCLES  (LS),
    .ENCLK_GAP_CYCLES    (GAP),
    .LOCK_TIMEOUT_CYCLES (TO)
  ) dut (
    .clkin         (clkin),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .relock_req    (relock_req),
    .pll_reset     (pll_reset),
    .pll_enclk     (pll_enclk),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #10 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running after 1ms, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  function automatic logic [5:0] obs();
    return {pll_reset, pll_enclk, sys_rst, ready};
  endfunction

  // Expected {pll_reset, enclk, sys_rst, ready} after edge t, given STABLE was entered at edge s.
  function automatic logic [5:0] exp_seq(int t, int s);
    logic [NC-1:0] en;
    logic          done;
    en = '0;
    for (int i = 0; i < NC; i++) en[i] = (t >= s + LS + i * GAP);
    done = (t >= s + LS + NC * GAP);
    return {1'b0, en, !done, done};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    pll_lock = 1'b0;
    relock_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_ready: ready=%b after 80 edges, required 1", ready);
    end
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    reset = 1'b1;
    pll_lock = 1'b0;
    relock_req = 1'b0;
    step();
    step();
    n_cmp++;
    if ({obs(), lock_lost_cnt} !== {6'b1_000_1_0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_values: got %h required %h", {obs(), lock_lost_cnt}, {6'b1_000_1_0, 8'd0});
    end
    reset = 1'b0;
    for (int k = 1; k <= PR + 6; k++) begin
      // relock pulses while the PLL is held in reset must not extend the pulse
      relock_req = (k <= PR) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      exp = {(k < PR), 3'b000, 1'b1, 1'b0, 8'd0};
      n_cmp++;
      if ({obs(), lock_lost_cnt} !== exp) begin
        n_bad++;
        $display("FAIL pll_rst_pulse edge %0d: got %h required %h", k, {obs(), lock_lost_cnt}, exp);
      end
    end
    relock_req = 1'b0;
  endtask

  task automatic test_bringup();
    int e;
    logic [5:0] exp;
    do_reset();
    repeat ($urandom_range(5, 12)) step();
    pll_lock = 1'b1;
    e = cyc + 1;
    for (int k = 0; k < 22; k++) begin
      step();
      exp = exp_seq(cyc, e + 2);
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL bringup edge e+%0d: got %b required %b", cyc - e, obs(), exp);
      end
    end
  endtask

  task automatic test_stable_glitch();
    int e;
    int f;
    logic [13:0] exp;
    do_reset();
    repeat ($urandom_range(5, 10)) step();
    pll_lock = 1'b1;
    e = cyc + 1;
    f = e + $urandom_range(1, 8);
    for (int k = 0; k < 40; k++) begin
      if (cyc + 1 == f) pll_lock = 1'b0;
      else pll_lock = 1'b1;
      step();
      exp = {exp_seq(cyc, f + 3), 8'd0};
      n_cmp++;
      if ({obs(), lock_lost_cnt} !== exp) begin
        n_bad++;
        $display("FAIL stable_glitch edge e+%0d (glitch e+%0d): got %h required %h",
                 cyc - e, f - e, {obs(), lock_lost_cnt}, exp);
      end
      if (cyc >= f + 20) break;
    end
    pll_lock = 1'b1;
  endtask

  task automatic test_lock_loss();
    bit ok;
    int d;
    logic [7:0] exp_c;
    do_reset();
    pll_lock = 1'b1;
    wait_ready(ok);
    repeat ($urandom_range(0, 5)) step();
    pll_lock = 1'b0;
    d = cyc + 1;
    step();
    step();
    n_cmp++;
    if ({obs(), lock_lost_cnt} !== {6'b0_111_0_1, 8'd0}) begin
      n_bad++;
      $display("FAIL loss_before_react: got %h required %h", {obs(), lock_lost_cnt}, {6'b0_111_0_1, 8'd0});
    end
    step();
    n_cmp++;
    if ({obs(), lock_lost_cnt} !== {6'b1_000_1_0, 8'd1}) begin
      n_bad++;
      $display("FAIL loss_react edge d+%0d: got %h required %h", cyc - d, {obs(), lock_lost_cnt}, {6'b1_000_1_0, 8'd1});
    end
    for (int k = 2; k <= 256; k++) begin
      pll_lock = 1'b1;
      wait_ready(ok);
      if (!ok) break;
      repeat ($urandom_range(0, 3)) step();
      pll_lock = 1'b0;
      repeat (3) step();
      exp_c = (k > 255) ? 8'd255 : 8'(k);
      n_cmp++;
      if (lock_lost_cnt !== exp_c) begin
        n_bad++;
        $display("FAIL loss_count after %0d losses: got %0d required %0d", k, lock_lost_cnt, exp_c);
      end
    end
    // asynchronous reset between clock edges clears everything at once
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({obs(), lock_lost_cnt} !== {6'b1_000_1_0, 8'd0}) begin
      n_bad++;
      $display("FAIL async_reset: got %h required %h", {obs(), lock_lost_cnt}, {6'b1_000_1_0, 8'd0});
    end
    @(negedge clkin);
  endtask

  task automatic test_relock();
    bit ok;
    int r;
    int p;
    logic [5:0] exp;
    do_reset();
    pll_lock = 1'b1;
    wait_ready(ok);
    repeat ($urandom_range(0, 4)) step();
    relock_req = 1'b1;
    r = cyc + 1;
    step();
    relock_req = 1'b0;
    n_cmp++;
    if ({obs(), lock_lost_cnt} !== {6'b1_000_1_0, 8'd0}) begin
      n_bad++;
      $display("FAIL relock_react: got %h required %h", {obs(), lock_lost_cnt}, {6'b1_000_1_0, 8'd0});
    end
    p = $urandom_range(1, PR - 1);
    for (int k = 1; k <= 26; k++) begin
      relock_req = (k == p);
      step();
      exp = exp_seq(cyc, r + PR + 1);
      exp[5] = (cyc < r + PR);
      n_cmp++;
      if ({obs(), lock_lost_cnt} !== {exp, 8'd0}) begin
        n_bad++;
        $display("FAIL relock_reseq edge r+%0d: got %h required %h", k, {obs(), lock_lost_cnt}, {exp, 8'd0});
      end
    end
    relock_req = 1'b0;
    // relock coinciding with the edge that acts on lock loss counts once
    pll_lock = 1'b0;
    step();
    step();
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    n_cmp++;
    if ({obs(), lock_lost_cnt} !== {6'b1_000_1_0, 8'd1}) begin
      n_bad++;
      $display("FAIL relock_with_loss: got %h required %h", {obs(), lock_lost_cnt}, {6'b1_000_1_0, 8'd1});
    end
    step();
    n_cmp++;
    if (lock_lost_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL relock_with_loss_hold: got %0d required 1", lock_lost_cnt);
    end
    pll_lock = 1'b1;
  endtask

  task automatic test_timeout();
    int t;
    logic       exp_r;
    logic [7:0] exp_c;
    do_reset();
    for (int k = 0; k < 3 * (PR + TO) + $urandom_range(4, 12); k++) begin
      step();
      t = cyc - rel_cyc;
`ifdef PLL_SEQ_TIMEOUT_EN
      exp_r = ((t % (PR + TO)) < PR);
      exp_c = 8'(t / (PR + TO));
`else
      exp_r = (t < PR);
      exp_c = 8'd0;
`endif
      n_cmp++;
      if ({pll_reset, lock_lost_cnt} !== {exp_r, exp_c}) begin
        n_bad++;
        $display("FAIL timeout edge %0d: pll_reset=%b cnt=%0d required pll_reset=%b cnt=%0d",
                 t, pll_reset, lock_lost_cnt, exp_r, exp_c);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    pll_lock = 1'b0;
    relock_req = 1'b0;
    @(negedge clkin);
    test_reset();
    test_bringup();
    test_stable_glitch();
    test_lock_loss();
    test_relock();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
